mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Execute-stage multiply/divide unit of the MIPS core. Accepts MULT/MULTU/DIV/DIVU
//  operands from EX, computes the 64-bit {hi,lo} result over several cycles, and drives
//  the hi/lo register write port (hilo_we, hi_o, lo_o). Raises busy so the hazard unit
//  stalls the pipeline until done.
// PARAMETERS
//  DATA_W   32  operand width; hi/lo are DATA_W each
//  MUL_LAT  2   cycles from accepted start to done for multiply (>=1)
// PORTS
//  clk       in   1       clock; all state updates on posedge
//  rst       in   1       synchronous, active-high reset
//  start     in   1       request; sampled only when idle (busy=0)
//  op        in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  src_a     in   DATA_W  rs operand (multiplicand / dividend)
//  src_b     in   DATA_W  rt operand (multiplier / divisor)
//  cancel    in   1       exception flush; aborts the in-flight operation
//  busy      out  1       operation in flight; stall request to hazard unit
//  hilo_we   out  1       one-cycle write strobe to hi/lo register (= done)
//  hi_o      out  DATA_W  result hi: product[63:32] or remainder
//  lo_o      out  DATA_W  result lo: product[31:0] or quotient
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE; busy=0, hilo_we=0, hi_o=0, lo_o=0; any op discarded.
//  FSM states: IDLE, MUL, DIV, DONE.
//   IDLE: start=1 & cancel=0 -> latch op/operands; MUL if op[1]=0 else DIV.
//   MUL: counts MUL_LAT-1 cycles, product registered -> DONE.
//   DIV: 32 radix-2 restoring iterations, one per cycle -> DONE.
//   DONE: hilo_we=1 for exactly this cycle, hi_o/lo_o valid -> IDLE.
//  Latency (start sampled in cycle N): multiply hilo_we in cycle N+MUL_LAT;
//   divide hilo_we in cycle N+33. busy=1 from N+1 through the hilo_we cycle inclusive.
//  hi_o/lo_o are registered; they change only on entry to DONE and hold afterwards.
//  Signed ops: compute on magnitudes; product negated if sign(a)^sign(b);
//   quotient negated if sign(a)^sign(b); remainder takes sign of dividend.
//   Unsigned ops: operands zero-extended; full 64-bit product.
//  Divide by zero (src_b=0): runs full 33 cycles; hi_o=src_a, lo_o=all ones (32'hFFFFFFFF).
//  Overflow DIV 0x80000000 / -1: lo_o=0x80000000, hi_o=0 (wrap, no trap).
//  start while busy: ignored (not queued). start and cancel same idle cycle: cancel wins.
//  cancel in MUL/DIV/DONE: next state IDLE, hilo_we forced 0 that cycle, hi_o/lo_o unchanged.
//  rst mid-operation: same as reset, no write strobe.
// STRUCTURE
//  mdu_pkg: op encodings (MDU_MULT..MDU_DIVU), FSM state encodings, DIV_ITERS=32.
//  Sub-module div_radix2: iterative restoring divider core (load, 32 steps, q/r out);
//   multiply is an inline registered product plus MUL_LAT-1 cycle counter in the top.
//  Sign fix-up and divide-by-zero override live in the top, before the hi/lo registers.
// TESTING
//  MULT 0xFFFFFFFF*0x00000002 -> hilo_we at N+2, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high N+1..N+2.
//  DIV -7/2 -> hilo_we at N+33, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
//  DIVU 5/0 -> hi=5, lo=0xFFFFFFFF at N+33; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  DIV started, cancel at N+10 -> idle at N+11, no hilo_we, hi/lo hold prior values;
//   new start at N+11 accepted.
//  start pulsed during busy -> ignored, single hilo_we; rst at N+5 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// the small bundle of sign/override flags latched when an op is accepted.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } mdu_state_e;

    localparam int DIV_ITERS = 32;

    // Result fix-up flags for the divide path, captured with the operands.
    typedef struct packed {
        logic q_neg;
        logic r_neg;
        logic div0;
    } mdu_ctx_t;

endpackage

// File: rtl/div_radix2.sv
// Iterative restoring divider on unsigned magnitudes: load, then one
// quotient bit per step. q_nxt/r_nxt are the values after the current step.
module div_radix2 import mdu_pkg::*; #(
    parameter int W = DIV_ITERS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] q_nxt,
    output logic [W-1:0] r_nxt,
    output logic         last
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  q, r, d;
    logic [CW-1:0] cnt;
    logic [W:0]    r_sh, diff;

    // q doubles as the dividend shift register; its MSB feeds the remainder.
    always_comb begin
        r_sh  = {r, q[W-1]};
        diff  = r_sh - {1'b0, d};
        q_nxt = {q[W-2:0], ~diff[W]};
        r_nxt = diff[W] ? r_sh[W-1:0] : diff[W-1:0];
    end

    assign last = (cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            r   <= '0;
            d   <= '0;
            cnt <= '0;
        end else if (load) begin
            q   <= dividend;
            r   <= '0;
            d   <= divisor;
            cnt <= '0;
        end else if (step) begin
            q   <= q_nxt;
            r   <= r_nxt;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage MULT/MULTU/DIV/DIVU unit. Multi-cycle, drives the hi/lo
// write port and holds busy for the hazard unit until the result is written.
module mul_div_unit import mdu_pkg::*; #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    output logic              busy,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

    mdu_state_e          state;
    mdu_ctx_t            ctx;
    logic [DATA_W-1:0]   a_raw;
    logic [CNT_W-1:0]    mul_cnt;
    logic [2*DATA_W-1:0] prod_q;

    logic                is_signed, a_neg, b_neg, accept, div_load, div_last;
    logic [DATA_W-1:0]   a_mag, b_mag, div_q, div_r, q_fix, r_fix;
    logic [2*DATA_W-1:0] prod_mag, prod_now;

    // Both signed and unsigned ops run on magnitudes; signs are restored after.
    always_comb begin
        is_signed = (op == MDU_MULT) || (op == MDU_DIV);
        a_neg     = is_signed & src_a[DATA_W-1];
        b_neg     = is_signed & src_b[DATA_W-1];
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -src_b : src_b;
        prod_mag  = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
        prod_now  = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
        accept    = (state == S_IDLE) && start && !cancel;
        div_load  = accept && op[1];
    end

    div_radix2 #(.W(DATA_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (state == S_DIV),
        .dividend (a_mag),
        .divisor  (b_mag),
        .q_nxt    (div_q),
        .r_nxt    (div_r),
        .last     (div_last)
    );

    always_comb begin
        q_fix = ctx.q_neg ? -div_q : div_q;
        r_fix = ctx.r_neg ? -div_r : div_r;
        if (ctx.div0) begin
            q_fix = '1;
            r_fix = a_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ctx     <= '0;
            a_raw   <= '0;
            mul_cnt <= '0;
            prod_q  <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ctx.q_neg <= a_neg ^ b_neg;
                        ctx.r_neg <= a_neg;
                        ctx.div0  <= (src_b == '0);
                        a_raw     <= src_a;
                        mul_cnt   <= '0;
                        prod_q    <= prod_now;
                        if (op[1]) begin
                            state <= S_DIV;
                        end else if (MUL_LAT == 1) begin
                            state         <= S_DONE;
                            {hi_o, lo_o}  <= prod_now;
                        end else begin
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else if (mul_cnt == CNT_W'(MUL_LAT - 2)) begin
                        state        <= S_DONE;
                        {hi_o, lo_o} <= prod_q;
                    end else begin
                        mul_cnt <= mul_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else if (div_last) begin
                        state <= S_DONE;
                        hi_o  <= r_fix;
                        lo_o  <= q_fix;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    // A flush or reset landing on the write cycle must not commit hi/lo.
    assign hilo_we = (state == S_DONE) && !cancel && !rst;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected {hi,lo} and write cycle are
// queued at issue and checked when hilo_we fires.
module tb_mul_div_unit;

    localparam int W       = 32;
    localparam int MUL_LAT = 2;

    typedef struct {
        string       name;
        logic [63:0] res;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, cancel;
    logic [1:0]    op;
    logic [W-1:0]  src_a, src_b;
    logic          busy, hilo_we;
    logic [W-1:0]  hi_o, lo_o;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    exp_t          sb[$];
    logic [63:0]   last_res;

    mul_div_unit #(.DATA_W(W), .MUL_LAT(MUL_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .cancel  (cancel),
        .busy    (busy),
        .hilo_we (hilo_we),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (hilo_we) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_hilo_we cyc=%0d hi=%h lo=%h", cyc, hi_o, lo_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({hi_o, lo_o} !== e.res || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL %s got hi=%h lo=%h cyc=%0d, expected hi=%h lo=%h cyc=%0d",
                             e.name, hi_o, lo_o, cyc, e.res[63:32], e.res[31:0], e.cyc);
                end
                last_res = e.res;
            end
        end
    end

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint pa, pb;
        int     sa, sb_i;
        case (o)
            2'b00: begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
                return 64'(pa * pb);
            end
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa   = a;
                sb_i = b;
                return {32'(sa % sb_i), 32'(sa / sb_i)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called just after a posedge; leaves the bench one cycle later with start low.
    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input bit track);
        exp_t e;
        start = 1'b1; op = o; src_a = a; src_b = b;
        if (track) begin
            e.name = name;
            e.res  = exp_res;
            e.cyc  = cyc + (o[1] ? 33 : MUL_LAT);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d expected=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, hilo_we, hi_o, lo_o} !== 66'b0) begin
            failures++;
            $display("FAIL reset busy=%b we=%b hi=%h lo=%h expected all 0", busy, hilo_we, hi_o, lo_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mult;
        issue("mult_neg", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 1);
        wait_done("mult_neg");
        issue("mult_mixed", 2'b00, 32'h0001_2345, 32'hFFFF_F000, model(2'b00, 32'h0001_2345, 32'hFFFF_F000), 1);
        wait_done("mult_mixed");
    endtask

    task automatic test_multu;
        issue("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== (k <= 2)) begin
                failures++;
                $display("FAIL multu_busy_N+%0d busy=%b expected %b", k, busy, (k <= 2));
            end
            @(posedge clk); #1;
        end
        wait_done("multu_max");
    endtask

    task automatic test_div;
        issue("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1);
        wait_done("div_neg7_2");
        issue("divu_100_7", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1);
        wait_done("divu_100_7");
        issue("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE, model(2'b10, 32'd7, 32'hFFFF_FFFE), 1);
        wait_done("div_7_neg2");
    endtask

    task automatic test_boundary;
        issue("divu_by_zero", 2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1);
        wait_done("divu_by_zero");
        issue("div_by_zero", 2'b10, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 1);
        wait_done("div_by_zero");
        issue("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1);
        wait_done("div_overflow");
    endtask

    task automatic test_cancel;
        logic [63:0] held;
        held = last_res;
        issue("div_cancelled", 2'b10, 32'd1000, 32'd3, 64'h0, 0);
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || {hi_o, lo_o} !== held) begin
            failures++;
            $display("FAIL cancel_idle busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                     busy, hi_o, lo_o, held[63:32], held[31:0]);
        end
        issue("after_cancel", 2'b11, 32'd9, 32'd4, {32'd1, 32'd2}, 1);
        wait_done("after_cancel");
        // start together with cancel while idle must be dropped
        start = 1'b1; cancel = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_cancel_same_cycle busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        issue("mult_busy_start", 2'b00, 32'd6, 32'd7, {32'd0, 32'd42}, 1);
        start = 1'b1; op = 2'b11; src_a = 32'd50; src_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("mult_busy_start");
        repeat (40) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i == 2) ? 32'($urandom_range(1, 9)) : $urandom;
            issue($sformatf("rand%0d_op%0d", i, o), o, a, b, model(o, a, b), 1);
            wait_done($sformatf("rand%0d", i));
        end
    endtask

    task automatic test_rst_mid;
        issue("div_reset", 2'b10, 32'd77, 32'd5, 64'h0, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, hilo_we, hi_o, lo_o} !== 66'b0) begin
            failures++;
            $display("FAIL rst_mid busy=%b we=%b hi=%h lo=%h expected all 0", busy, hilo_we, hi_o, lo_o);
        end
        repeat (40) @(posedge clk);
        #1;
    endtask

    initial begin
        last_res = '0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_boundary();
        test_cancel();
        test_back_to_back();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
